alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that computes WIDTH-bit AND, OR, ADD and SUB operations by time-multiplexing a single `alu_1bit` slice, one bit per clock, LSB first. It sits between a requesting block and one external `alu_1bit` instance. It latches the operands and iterates the slice with the carry held in a register. It returns a registered result with a one-cycle `done` pulse.

---
 rtl/alu_serial_ctrl.sv | 114 +++++++++++
 tb/tb_alu_serial_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial AND/OR/ADD/SUB sequencer driving one external alu_1bit slice,
// LSB first, one bit per clock, with the carry held in a register between bits.
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout_out,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic [1:0]       alu_s_op,
   input  logic             alu_z,
   input  logic             alu_cout
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_r;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [1:0]       op_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             carry_nxt;

   // AND/OR never propagate a carry; op_r[1] marks the arithmetic ops.
   assign carry_nxt = op_r[1] & alu_cout;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      alu_a    = 1'b0;
      alu_b    = 1'b0;
      alu_cin  = 1'b0;
      alu_s_op = 2'b00;
      if (state_r == S_RUN) begin
         alu_a    = a_sh[0];
         alu_b    = b_sh[0];
         alu_cin  = carry_r;
         alu_s_op = (op_r == OP_SUB) ? OP_ADD : op_r;
      end
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= S_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         op_r     <= 2'b00;
         cnt_r    <= '0;
         carry_r  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  // SUB is a + ~b + 1, so invert b here and seed the carry with 1.
                  a_sh    <= a_in;
                  b_sh    <= (op == OP_SUB) ? ~b_in : b_in;
                  op_r    <= op;
                  cnt_r   <= '0;
                  carry_r <= (op == OP_ADD) ? cin_in : (op == OP_SUB);
                  busy    <= 1'b1;
                  state_r <= S_RUN;
               end
            end
            S_RUN: begin
               res_sh  <= {alu_z, res_sh[WIDTH-1:1]};
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry_r <= carry_nxt;
               cnt_r   <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  result   <= {alu_z, res_sh[WIDTH-1:1]};
                  cout_out <= carry_nxt;
                  cnt_r    <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a behavioural alu_1bit
// slice on the slice ports; each task checks its own cycle-exact expectations.
module tb_alu_serial_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout_out;
   logic       alu_a;
   logic       alu_b;
   logic       alu_cin;
   logic [1:0] alu_s_op;
   logic       alu_z;
   logic       alu_cout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_serial_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout_out (cout_out),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_cin  (alu_cin),
      .alu_s_op (alu_s_op),
      .alu_z    (alu_z),
      .alu_cout (alu_cout)
   );

   // One-bit slice: 00 AND, 01 OR, 10 full adder.
   always_comb begin
      alu_z    = 1'b0;
      alu_cout = 1'b0;
      case (alu_s_op)
         2'b00: alu_z = alu_a & alu_b;
         2'b01: alu_z = alu_a | alu_b;
         default: begin
            alu_z    = alu_a ^ alu_b ^ alu_cin;
            alu_cout = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
         end
      endcase
   end

   // Called at a negedge; returns at the negedge of cycle 10 (next op lands 10 cycles later).
   task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] exp_res, input logic exp_cout,
                         input string nm);
      start  = 1'b1;
      op     = o;
      a_in   = a;
      b_in   = b;
      cin_in = c;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      op     = ~o;
      a_in   = ~a;
      b_in   = ~b;
      cin_in = ~c;
      for (int k = 1; k <= 9; k++) begin
         n_cmp++;
         if (busy !== (k <= 8)) begin
            $display("FAIL %s busy cycle %0d: got %b want %b", nm, k, busy, (k <= 8));
            n_bad++;
         end
         n_cmp++;
         if (done !== (k == 9)) begin
            $display("FAIL %s done cycle %0d: got %b want %b", nm, k, done, (k == 9));
            n_bad++;
         end
         if (k == 9) begin
            n_cmp++;
            if (result !== exp_res) begin
               $display("FAIL %s result: got %h want %h", nm, result, exp_res);
               n_bad++;
            end
            n_cmp++;
            if (cout_out !== exp_cout) begin
               $display("FAIL %s cout: got %b want %b", nm, cout_out, exp_cout);
               n_bad++;
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL %s idle after done: got busy=%b done=%b want 0 0", nm, busy, done);
         n_bad++;
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a_in   = 8'h00;
      b_in   = 8'h00;
      cin_in = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, cout_out, result} !== 11'h0) begin
         $display("FAIL reset outputs: got busy=%b done=%b cout=%b result=%h want all 0",
                  busy, done, cout_out, result);
         n_bad++;
      end
      n_cmp++;
      if ({alu_a, alu_b, alu_cin, alu_s_op} !== 5'b0) begin
         $display("FAIL reset slice inputs: got %b%b%b %b want 000 00",
                  alu_a, alu_b, alu_cin, alu_s_op);
         n_bad++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      run_op(2'b10, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
      n_cmp++;
      if ({alu_a, alu_b, alu_cin, alu_s_op} !== 5'b0) begin
         $display("FAIL idle slice inputs: got %b%b%b %b want 000 00",
                  alu_a, alu_b, alu_cin, alu_s_op);
         n_bad++;
      end
      run_op(2'b10, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      run_op(2'b10, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_cin");
   endtask

   task automatic test_sub();
      run_op(2'b11, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01");
      run_op(2'b11, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, "sub_borrow");
   endtask

   task automatic test_logic();
      run_op(2'b00, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, "and");
      run_op(2'b00, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, "and_cin1");
      run_op(2'b01, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, "or");
      run_op(2'b01, 8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0, "or_cin1");
   endtask

   // start stays high with new operands through RUN and DONE; it must be ignored there.
   task automatic test_start_held();
      start  = 1'b1;
      op     = 2'b10;
      a_in   = 8'h5A;
      b_in   = 8'h3C;
      cin_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      op     = 2'b11;
      a_in   = 8'h01;
      b_in   = 8'h77;
      cin_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         n_cmp++;
         if (busy !== (k <= 8) || done !== (k == 9)) begin
            $display("FAIL held busy/done cycle %0d: got %b/%b want %b/%b",
                     k, busy, done, (k <= 8), (k == 9));
            n_bad++;
         end
         if (k == 9) begin
            n_cmp++;
            if (result !== 8'h96 || cout_out !== 1'b0) begin
               $display("FAIL held result: got %h/%b want 96/0", result, cout_out);
               n_bad++;
            end
            start = 1'b0;
         end
         @(negedge clk);
      end
      for (int k = 10; k <= 11; k++) begin
         n_cmp++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL held no_queue cycle %0d: got busy=%b done=%b want 0 0", k, busy, done);
            n_bad++;
         end
         @(negedge clk);
      end
   endtask

   // Reset pulsed in cycle 4 of an ADD after a prior result of FF.
   task automatic test_reset_mid_run();
      run_op(2'b01, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, "pre_abort");
      start  = 1'b1;
      op     = 2'b10;
      a_in   = 8'h5A;
      b_in   = 8'h3C;
      cin_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         $display("FAIL abort pre busy: got %b want 1", busy);
         n_bad++;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || result !== 8'h00 || cout_out !== 1'b0 || done !== 1'b0) begin
         $display("FAIL abort immediate: got busy=%b result=%h cout=%b done=%b want 0 00 0 0",
                  busy, result, cout_out, done);
         n_bad++;
      end
      #2;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL abort no_done step %0d: got done=%b busy=%b want 0 0", k, done, busy);
            n_bad++;
         end
      end
      run_op(2'b10, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "after_abort");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_start_held();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
